// File: rtl/pipe_pkg.sv
`default_nettype none
// pipe_pkg: shared encodings for the RISC_toy hazard controller.  rev 1.0
package pipe_pkg;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_M  = 2'd1;
  localparam logic [1:0] FWD_W  = 2'd2;

  localparam int unsigned TIMER_W = 8;

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_MEMWAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic pc_stall;
    logic fd_stall;
    logic fd_flush;
    logic de_stall;
    logic de_flush;
    logic em_stall;
    logic redirect;
  } ctl_t;

  // The register-write enables are active-low, and r0 is hardwired to zero.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] ra,
    input logic [4:0] wa_m,
    input logic       wen_n_m,
    input logic [4:0] wa_w,
    input logic       wen_n_w
  );
    if (!wen_n_m && (wa_m == ra) && (ra != 5'd0)) begin
      return FWD_M;
    end
    if (!wen_n_w && (wa_w == ra) && (ra != 5'd0)) begin
      return FWD_W;
    end
    return FWD_RF;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_fwd.sv
`default_nettype none
// hazard_fwd_unit: E-stage operand forwarding select, M result has priority over W.  rev 1.0
module hazard_fwd_unit
  import pipe_pkg::*;
(
  input  logic [4:0] ra0_e_i,
  input  logic [4:0] ra1_e_i,
  input  logic [4:0] wa_m_i,
  input  logic       wen_m_i,
  input  logic [4:0] wa_w_i,
  input  logic       wen_w_i,
  output logic [1:0] fwd0_o,
  output logic [1:0] fwd1_o
);

  always_comb begin
    fwd0_o = fwd_sel(ra0_e_i, wa_m_i, wen_m_i, wa_w_i, wen_w_i);
    fwd1_o = fwd_sel(ra1_e_i, wa_m_i, wen_m_i, wa_w_i, wen_w_i);
  end

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// pipe_hazard_ctrl: stall/flush sequencing, memory-wait FSM with timeout and event counters
// for the 5-stage RISC_toy pipeline.  rev 1.0
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [4:0]       RA0_D,
  input  logic [4:0]       RA1_D,
  input  logic             Use0_D,
  input  logic             Use1_D,
  input  logic [4:0]       RA0_E,
  input  logic [4:0]       RA1_E,
  input  logic [4:0]       WA_E,
  input  logic             WEN_E,
  input  logic             Load_E,
  input  logic             Jump_E,
  input  logic             Branch_E,
  input  logic             Taken_E,
  input  logic             Cond_E,
  input  logic [4:0]       WA_M,
  input  logic             WEN_M,
  input  logic [4:0]       WA_W,
  input  logic             WEN_W,
  input  logic             DREQ_M,
  input  logic             DACK,
  output logic             PCStall,
  output logic             FDStall,
  output logic             FDFlush,
  output logic             DEStall,
  output logic             DEFlush,
  output logic             EMStall,
  output logic             Redirect,
  output logic [1:0]       Fwd0_E,
  output logic [1:0]       Fwd1_E,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  localparam logic [TIMER_W-1:0] TMO_LAST = TIMER_W'(MEM_TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               memerr_q, memerr_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

  ctl_t       ctl;
  logic       mp_flush;
  logic       mp;
  logic       lu;
  logic       mem_req;
  logic [1:0] fwd0;
  logic [1:0] fwd1;

  hazard_fwd_unit u_fwd (
    .ra0_e_i (RA0_E),
    .ra1_e_i (RA1_E),
    .wa_m_i  (WA_M),
    .wen_m_i (WEN_M),
    .wa_w_i  (WA_W),
    .wen_w_i (WEN_W),
    .fwd0_o  (fwd0),
    .fwd1_o  (fwd1)
  );

  always_comb begin
    mp      = ((Jump_E | (Branch_E & Cond_E)) != Taken_E);
    lu      = Load_E & ~WEN_E & (WA_E != 5'd0) &
              ((Use0_D & (RA0_D == WA_E)) | (Use1_D & (RA1_D == WA_E)));
    mem_req = ~DREQ_M & ~DACK;
  end

  // A mispredict is never acted on inside MEMWAIT: E is frozen, so it is
  // picked up again from RUN once the memory access has finished.
  always_comb begin
    ctl      = '0;
    mp_flush = 1'b0;
    state_d  = state_q;
    timer_d  = timer_q;
    memerr_d = memerr_q;
    if (RST) begin
      ctl.fd_flush = 1'b1;
      ctl.de_flush = 1'b1;
      state_d      = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (mem_req) begin
            ctl.pc_stall = 1'b1;
            ctl.fd_stall = 1'b1;
            ctl.de_stall = 1'b1;
            ctl.em_stall = 1'b1;
            state_d      = ST_MEMWAIT;
            timer_d      = '0;
          end else if (mp) begin
            ctl.redirect = 1'b1;
            ctl.fd_flush = 1'b1;
            ctl.de_flush = 1'b1;
            mp_flush     = 1'b1;
          end else if (lu) begin
            ctl.pc_stall = 1'b1;
            ctl.fd_stall = 1'b1;
            ctl.de_flush = 1'b1;
          end
        end
        ST_MEMWAIT: begin
          if (DACK) begin
            state_d = ST_RUN;
          end else if (timer_q == TMO_LAST) begin
            memerr_d = 1'b1;
            state_d  = ST_RUN;
          end else begin
            ctl.pc_stall = 1'b1;
            ctl.fd_stall = 1'b1;
            ctl.de_stall = 1'b1;
            ctl.em_stall = 1'b1;
            timer_d      = timer_q + 1'b1;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q + CNT_W'(ctl.pc_stall);
    flush_cnt_d = flush_cnt_q + CNT_W'(mp_flush);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_RUN;
      timer_q     <= '0;
      memerr_q    <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      memerr_q    <= memerr_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    PCStall  = ctl.pc_stall;
    FDStall  = ctl.fd_stall;
    FDFlush  = ctl.fd_flush;
    DEStall  = ctl.de_stall;
    DEFlush  = ctl.de_flush;
    EMStall  = ctl.em_stall;
    Redirect = ctl.redirect;
    Fwd0_E   = RST ? FWD_RF : fwd0;
    Fwd1_E   = RST ? FWD_RF : fwd1;
    MemErr   = memerr_q;
    StallCnt = stall_cnt_q;
    FlushCnt = flush_cnt_q;
  end

endmodule
`default_nettype wire
